decode_fwd_reg: RTL and testbench
=================================

DECODE_FWD_REG -- requirements
Module: decode_fwd_reg

Interface
REQ-001 SHALL have parameter XLEN, default 64: data word width.
REQ-002 SHALL have parameter NREG, default 15: architectural register count; index 4'hF is RNONE.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports D_icode, D_ifun, D_rA, D_rB, D_stat  in  4 each: decode-stage register contents.
REQ-006 SHALL have ports D_valC, D_valP  in  XLEN each: constant word and next PC.
REQ-007 SHALL have ports e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  4 each: forwarding destination IDs.
REQ-008 SHALL have ports e_valE, M_valE, m_valM, W_valE, W_valM  in  XLEN each: forwarding data.
REQ-009 SHALL have port e_mispredict  in  1: flush request for the execute-bound instruction.
REQ-010 SHALL have ports E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB  out  4 each: registered execute-stage fields.
REQ-011 SHALL have ports E_valA, E_valB, E_valC  out  XLEN each: registered operands.
REQ-012 SHALL have port d_stall  out  1: combinational; upstream holds F and D while high.

Function
REQ-013 SHALL decode srcA/srcB/dstE/dstM from D_icode: 2 {rA,RNONE,rB,RNONE}; 3 {RNONE,RNONE,rB,RNONE}; 4 {rA,rB,RNONE,RNONE}; 5 {RNONE,rB,RNONE,rA}; 6 {rA,rB,rB,RNONE}; 8 {RNONE,4,4,RNONE}; 9/B srcA=srcB=4, dstE=4, dstM=RNONE/rA; A {rA,4,4,RNONE}; all other icodes all four RNONE.
REQ-014 SHALL select valA = D_valP when D_icode is 7 or 8, otherwise forwarded srcA.
REQ-015 SHALL forward with strict priority e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, then register file; RNONE never matches.
REQ-016 SHALL contain NREG x XLEN registers written at clk from W_dstE/W_valE and W_dstM/W_valM; W_dstM wins when both name the same register; RNONE writes ignored.
REQ-017 SHALL provide write-through: a register-file read in the cycle that register is written returns the new value.
REQ-018 SHALL assert d_stall when E_icode is 5 or B and E_dstM != RNONE and E_dstM equals srcA or srcB (load-use).
REQ-019 SHALL load the E register with a bubble (icode 1, ifun 0, all IDs RNONE, vals 0, stat 1/AOK) when d_stall or e_mispredict is high; otherwise load decoded values; E_stat = D_stat.
REQ-020 SHALL give e_mispredict priority when simultaneous with d_stall; bubble inserted once; d_stall still reported.
REQ-021 SHALL have one-cycle latency from D inputs to E outputs.

Reset
REQ-022 SHALL, while rst_n is low, asynchronously force the E register to the bubble of REQ-019 and all register-file entries to 0.
REQ-023 SHALL, on deassertion mid-stream, resume from the bubble with no partial E contents retained.

Configuration
REQ-024 SHALL, with DECODE_FWD_EN defined, implement forwarding per REQ-015 and stall only per REQ-018.
REQ-025 SHALL, without DECODE_FWD_EN, perform no e/M forwarding: assert d_stall when srcA or srcB (not RNONE) equals e_dstE, M_dstE or M_dstM, or per REQ-018; W values reach operands only via REQ-017.

Structure
REQ-026 SHALL take icode constants, RNONE, RSP (4), stat codes and the bubble constant from shared package y86_pkg.
REQ-027 SHALL instantiate the register file as sub-module y86_regfile (two read, two write ports, async reset).

Verification
REQ-028 SHALL cover: W_dstE=3, W_valE=0x55 written; next D=OPq rA=3 rB=3 -> E_valA=E_valB=0x55, E_dstE=3.
REQ-029 SHALL cover: e_dstE=2/e_valE=0xA, M_dstE=2/M_valE=0xB, D=rrmovq rA=2 -> E_valA=0xA (priority).
REQ-030 SHALL cover: E = mrmovq dstM=5, D = addq rA=5 -> d_stall=1, next E_icode=1; following cycle decodes addq, E_valA from m_valM.
REQ-031 SHALL cover: e_mispredict=1 with D=irmovq -> next E is bubble; d_stall=1 together -> single bubble.
REQ-032 SHALL cover: D=call (8), D_valP=0x40 -> E_valA=0x40, E_srcB=4, E_dstE=4; W_dstE=W_dstM=6 same cycle -> reg 6 = W_valM.
REQ-033 SHALL cover: rst_n low mid-run -> E outputs bubble immediately, register 0-14 read 0; build without DECODE_FWD_EN, e_dstE=2, D rA=2 -> d_stall=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: instruction codes, register IDs,
// status codes and the execute-stage bubble.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register IDs
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_ADR = 4'h2;
  localparam logic [3:0] S_INS = 4'h3;
  localparam logic [3:0] S_HLT = 4'h4;

  // Control/ID half of the E register; data words are sized by XLEN locally.
  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] stat;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } e_ctrl_t;

  // Bubble: a nop with no register traffic and AOK status (data words are 0).
  localparam e_ctrl_t BUBBLE_CTRL = '{
    icode: I_NOP, ifun: 4'h0, stat: S_AOK,
    dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE
  };

  // Instructions whose result only becomes available after the memory stage.
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86 register file: NREG x XLEN, two combinational read ports with
// write-through, two write ports (M port wins on collision), async reset.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      raddr_a,
  input  logic [3:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic [3:0]      wdst_e,
  input  logic [XLEN-1:0] wval_e,
  input  logic [3:0]      wdst_m,
  input  logic [XLEN-1:0] wval_m
);

  logic [NREG-1:0][XLEN-1:0] regs;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [XLEN-1:0] q_reg;

      // One architectural register; the memory-result port has priority.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (wdst_m == 4'(gi)) begin
          q_reg <= wval_m;
        end else if (wdst_e == 4'(gi)) begin
          q_reg <= wval_e;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  // Read with write-through so a value written this cycle is visible now.
  function automatic logic [XLEN-1:0] read_port(input logic [3:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr != RNONE) begin
      if (addr == wdst_m) begin
        val = wval_m;
      end else if (addr == wdst_e) begin
        val = wval_e;
      end else begin
        for (int i = 0; i < NREG; i++) begin
          if (addr == i[3:0]) val = regs[i];
        end
      end
    end
    return val;
  endfunction

  // Both read ports share the same bypass rules.
  always_comb begin
    rdata_a = read_port(raddr_a);
    rdata_b = read_port(raddr_b);
  end

endmodule

// File: rtl/decode_fwd_reg.sv
// Y86 decode stage plus D->E pipeline register.
// Build option DECODE_FWD_EN: when defined, operands are forwarded from
// e/M/W; when undefined, any e/M dependency stalls and W values arrive
// only through register-file write-through.
module decode_fwd_reg
  import y86_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      D_icode,
  input  logic [3:0]      D_ifun,
  input  logic [3:0]      D_rA,
  input  logic [3:0]      D_rB,
  input  logic [3:0]      D_stat,
  input  logic [XLEN-1:0] D_valC,
  input  logic [XLEN-1:0] D_valP,
  input  logic [3:0]      e_dstE,
  input  logic [3:0]      M_dstE,
  input  logic [3:0]      M_dstM,
  input  logic [3:0]      W_dstE,
  input  logic [3:0]      W_dstM,
  input  logic [XLEN-1:0] e_valE,
  input  logic [XLEN-1:0] M_valE,
  input  logic [XLEN-1:0] m_valM,
  input  logic [XLEN-1:0] W_valE,
  input  logic [XLEN-1:0] W_valM,
  input  logic            e_mispredict,
  output logic [3:0]      E_icode,
  output logic [3:0]      E_ifun,
  output logic [3:0]      E_stat,
  output logic [3:0]      E_dstE,
  output logic [3:0]      E_dstM,
  output logic [3:0]      E_srcA,
  output logic [3:0]      E_srcB,
  output logic [XLEN-1:0] E_valA,
  output logic [XLEN-1:0] E_valB,
  output logic [XLEN-1:0] E_valC,
  output logic            d_stall
);

  logic [3:0]      src_a, src_b, dst_e, dst_m;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] opnd_a, opnd_b, val_a;
  logic            load_use, dep_stall;

  // Register IDs implied by the instruction code.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode)
      I_RRMOVQ: begin src_a = D_rA; dst_e = D_rB; end
      I_IRMOVQ: begin dst_e = D_rB; end
      I_RMMOVQ: begin src_a = D_rA; src_b = D_rB; end
      I_MRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
      I_OPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
      I_CALL:   begin src_b = RSP;  dst_e = RSP; end
      I_RET:    begin src_a = RSP;  src_b = RSP; dst_e = RSP; end
      I_POPQ:   begin src_a = RSP;  src_b = RSP; dst_e = RSP; dst_m = D_rA; end
      I_PUSHQ:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
      default:  ;
    endcase
  end

  y86_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (src_a),
    .raddr_b (src_b),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .wdst_e  (W_dstE),
    .wval_e  (W_valE),
    .wdst_m  (W_dstM),
    .wval_m  (W_valM)
  );

`ifdef DECODE_FWD_EN
  // Youngest producer wins; RNONE sources fall through to the file (reads 0).
  function automatic logic [XLEN-1:0] fwd_sel(input logic [3:0] src,
                                              input logic [XLEN-1:0] rf_val);
    logic [XLEN-1:0] v;
    v = rf_val;
    if (src != RNONE) begin
      if      (src == e_dstE) v = e_valE;
      else if (src == M_dstM) v = m_valM;
      else if (src == M_dstE) v = M_valE;
      else if (src == W_dstM) v = W_valM;
      else if (src == W_dstE) v = W_valE;
    end
    return v;
  endfunction

  // Forwarded operands; only load-use needs to stall.
  always_comb begin
    opnd_a    = fwd_sel(src_a, rf_a);
    opnd_b    = fwd_sel(src_b, rf_b);
    dep_stall = 1'b0;
  end
`else
  // No e/M bypass: wait until the producer reaches W (write-through).
  function automatic logic in_flight(input logic [3:0] src);
    return (src != RNONE) &&
           ((src == e_dstE) || (src == M_dstE) || (src == M_dstM));
  endfunction

  // Operands straight from the file; stall on any e/M dependency.
  always_comb begin
    opnd_a    = rf_a;
    opnd_b    = rf_b;
    dep_stall = in_flight(src_a) || in_flight(src_b);
  end
`endif

  // Load-use hazard against the instruction now in E, then stall/valA select.
  always_comb begin
    load_use = is_load(E_icode) && (E_dstM != RNONE) &&
               ((E_dstM == src_a) || (E_dstM == src_b));
    d_stall  = load_use || dep_stall;
    val_a    = ((D_icode == I_JXX) || (D_icode == I_CALL)) ? D_valP : opnd_a;
  end

  // E pipeline register: bubble on stall or mispredict, else decoded values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB} <= BUBBLE_CTRL;
      E_valA <= '0;
      E_valB <= '0;
      E_valC <= '0;
    end else if (e_mispredict || d_stall) begin
      {E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB} <= BUBBLE_CTRL;
      E_valA <= '0;
      E_valB <= '0;
      E_valC <= '0;
    end else begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_stat  <= D_stat;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
      E_valA  <= val_a;
      E_valB  <= opnd_b;
      E_valC  <= D_valC;
    end
  end

endmodule

// File: tb/tb_decode_fwd_reg.sv
// Directed bench for decode_fwd_reg. Expected E contents are queued when
// the D-stage stimulus is applied and checked after the following edge.
// Expectations that differ between builds follow DECODE_FWD_EN.
module tb_decode_fwd_reg;

  localparam logic [3:0] N = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        e_mispredict;
  logic [3:0]  E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        d_stall;

  typedef struct {
    logic [3:0]  icode, ifun, stat, dste, dstm, srca, srcb;
    logic [63:0] vala, valb, valc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  decode_fwd_reg #(.XLEN(64), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
    .e_mispredict(e_mispredict),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .d_stall(d_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_stat = 4'h1;
    D_valC = vc; D_valP = vp;
  endtask

  task automatic clr_fwd();
    e_dstE = N; M_dstE = N; M_dstM = N; W_dstE = N; W_dstM = N;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    e_mispredict = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] st,
                          input logic [3:0] de, input logic [3:0] dm, input logic [3:0] sa,
                          input logic [3:0] sb, input logic [63:0] va, input logic [63:0] vb,
                          input logic [63:0] vc);
    exp_t e;
    e.icode = ic; e.ifun = fn; e.stat = st; e.dste = de; e.dstm = dm;
    e.srca = sa; e.srcb = sb; e.vala = va; e.valb = vb; e.valc = vc;
    sbq.push_back(e);
  endtask

  task automatic push_bubble();
    push_exp(4'h1, 4'h0, 4'h1, N, N, N, N, 64'h0, 64'h0, 64'h0);
  endtask

  // Clock one transaction into E and compare it against the queued entry.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=no_expectation expected=queued_entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".icode"}, E_icode, e.icode);
      chk({tag, ".ifun"},  E_ifun,  e.ifun);
      chk({tag, ".stat"},  E_stat,  e.stat);
      chk({tag, ".dstE"},  E_dstE,  e.dste);
      chk({tag, ".dstM"},  E_dstM,  e.dstm);
      chk({tag, ".srcA"},  E_srcA,  e.srca);
      chk({tag, ".srcB"},  E_srcB,  e.srcb);
      chk({tag, ".valA"},  E_valA,  e.vala);
      chk({tag, ".valB"},  E_valB,  e.valb);
      chk({tag, ".valC"},  E_valC,  e.valc);
    end
    $display("txn %-10s E: icode=%h stat=%h dstE=%h dstM=%h srcA=%h srcB=%h valA=%0h valB=%0h valC=%0h",
             tag, E_icode, E_stat, E_dstE, E_dstM, E_srcA, E_srcB, E_valA, E_valB, E_valC);
  endtask

  task automatic chk_bubble_now(input string tag);
    chk({tag, ".icode"}, E_icode, 64'h1);
    chk({tag, ".ifun"},  E_ifun,  64'h0);
    chk({tag, ".stat"},  E_stat,  64'h1);
    chk({tag, ".dstE"},  E_dstE,  64'hF);
    chk({tag, ".dstM"},  E_dstM,  64'hF);
    chk({tag, ".srcA"},  E_srcA,  64'hF);
    chk({tag, ".srcB"},  E_srcB,  64'hF);
    chk({tag, ".valA"},  E_valA,  64'h0);
    chk({tag, ".valB"},  E_valB,  64'h0);
    chk({tag, ".valC"},  E_valC,  64'h0);
  endtask

  initial begin
    clr_fwd();
    set_d(4'h1, 4'h0, N, N, 64'h0, 64'h0);

    // Reset state
    #12;
    chk_bubble_now("reset");
    chk("reset.stall", d_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // W writes r3=0x55 while D holds a nop
    W_dstE = 4'h3; W_valE = 64'h55;
    push_exp(4'h1, 4'h0, 4'h1, N, N, N, N, 64'h0, 64'h0, 64'h0);
    tick("nop_wr3");
    clr_fwd();

    // OPq r3,r3 reads the written value on both ports
    set_d(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0);
    push_exp(4'h6, 4'h0, 4'h1, 4'h3, N, 4'h3, 4'h3, 64'h55, 64'h55, 64'h0);
    tick("opq_r3");

    // Forwarding priority: e_dstE over M_dstE
    e_dstE = 4'h2; e_valE = 64'hA; M_dstE = 4'h2; M_valE = 64'hB;
    set_d(4'h2, 4'h0, 4'h2, 4'h7, 64'h0, 64'h0);
    #1;
`ifdef DECODE_FWD_EN
    chk("prio.stall", d_stall, 1'b0);
    push_exp(4'h2, 4'h0, 4'h1, 4'h7, N, 4'h2, N, 64'hA, 64'h0, 64'h0);
`else
    chk("prio.stall", d_stall, 1'b1);
    push_bubble();
`endif
    tick("prio");
    clr_fwd();

    // Load-use: mrmovq -> r5, then addq reads r5
    set_d(4'h5, 4'h0, 4'h5, N, 64'h8, 64'h0);
    push_exp(4'h5, 4'h0, 4'h1, N, 4'h5, N, N, 64'h0, 64'h0, 64'h8);
    tick("mrmovq");
    set_d(4'h6, 4'h0, 4'h5, 4'h1, 64'h0, 64'h0);
    #1;
    chk("lu.stall", d_stall, 1'b1);
    push_bubble();
    tick("lu_bubble");
    M_dstM = 4'h5; m_valM = 64'h77;
    #1;
`ifdef DECODE_FWD_EN
    chk("lu.m_stall", d_stall, 1'b0);
    push_exp(4'h6, 4'h0, 4'h1, 4'h1, N, 4'h5, 4'h1, 64'h77, 64'h0, 64'h0);
    tick("lu_addq");
`else
    chk("lu.m_stall", d_stall, 1'b1);
    push_bubble();
    tick("lu_bubble2");
    clr_fwd();
    W_dstM = 4'h5; W_valM = 64'h77;
    #1;
    chk("lu.w_stall", d_stall, 1'b0);
    push_exp(4'h6, 4'h0, 4'h1, 4'h1, N, 4'h5, 4'h1, 64'h77, 64'h0, 64'h0);
    tick("lu_addq");
`endif
    clr_fwd();

    // Mispredict squashes an irmovq
    set_d(4'h3, 4'h0, N, 4'h2, 64'h99, 64'h0);
    e_mispredict = 1'b1;
    #1;
    chk("mp.stall", d_stall, 1'b0);
    push_bubble();
    tick("mp_irmovq");
    e_mispredict = 1'b0;

    // Mispredict together with load-use: exactly one bubble
    set_d(4'h5, 4'h0, 4'h6, N, 64'h0, 64'h0);
    push_exp(4'h5, 4'h0, 4'h1, N, 4'h6, N, N, 64'h0, 64'h0, 64'h0);
    tick("mrmovq6");
    set_d(4'h6, 4'h0, 4'h6, 4'h6, 64'h0, 64'h0);
    e_mispredict = 1'b1;
    #1;
    chk("mpst.stall", d_stall, 1'b1);
    push_bubble();
    tick("mpst_bub");
    e_mispredict = 1'b0;
    #1;
    chk("mpst.after", d_stall, 1'b0);
    push_exp(4'h6, 4'h0, 4'h1, 4'h6, N, 4'h6, 4'h6, 64'h0, 64'h0, 64'h0);
    tick("mpst_addq");

    // call: valA = valP, rsp source/dest; W_dstE/W_dstM collide on r6
    set_d(4'h8, 4'h0, N, N, 64'h100, 64'h40);
    W_dstE = 4'h6; W_valE = 64'h11; W_dstM = 4'h6; W_valM = 64'h22;
    push_exp(4'h8, 4'h0, 4'h1, 4'h4, N, N, 4'h4, 64'h40, 64'h0, 64'h100);
    tick("call");
    clr_fwd();
    set_d(4'h2, 4'h0, 4'h6, 4'h0, 64'h0, 64'h0);
    push_exp(4'h2, 4'h0, 4'h1, 4'h0, N, 4'h6, N, 64'h22, 64'h0, 64'h0);
    tick("rd_r6");

    // jXX also takes valP; pushq/popq rsp usage; halt passes its status
    set_d(4'h7, 4'h3, N, N, 64'h200, 64'h58);
    push_exp(4'h7, 4'h3, 4'h1, N, N, N, N, 64'h58, 64'h0, 64'h200);
    tick("jxx");
    set_d(4'hA, 4'h0, 4'h6, N, 64'h0, 64'h0);
    push_exp(4'hA, 4'h0, 4'h1, 4'h4, N, 4'h6, 4'h4, 64'h22, 64'h0, 64'h0);
    tick("pushq");
    set_d(4'h0, 4'h0, N, N, 64'h0, 64'h0);
    D_stat = 4'h4;
    push_exp(4'h0, 4'h0, 4'h4, N, N, N, N, 64'h0, 64'h0, 64'h0);
    tick("halt");
    set_d(4'hB, 4'h0, 4'h3, N, 64'h0, 64'h0);
    push_exp(4'hB, 4'h0, 4'h1, 4'h4, 4'h3, 4'h4, 4'h4, 64'h0, 64'h0, 64'h0);
    tick("popq");

    // Mid-run reset: E bubbles immediately, file clears
    rst_n = 1'b0;
    #1;
    chk_bubble_now("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_d(4'h6, 4'h0, 4'(i), 4'(i), 64'h0, 64'h0);
      push_exp(4'h6, 4'h0, 4'h1, 4'(i), N, 4'(i), 4'(i), 64'h0, 64'h0, 64'h0);
      tick($sformatf("rd0_r%0d", i));
    end

    // e-stage dependency on rA=2
    e_dstE = 4'h2; e_valE = 64'hA;
    set_d(4'h2, 4'h0, 4'h2, 4'h7, 64'h0, 64'h0);
    #1;
`ifdef DECODE_FWD_EN
    chk("edep.stall", d_stall, 1'b0);
    push_exp(4'h2, 4'h0, 4'h1, 4'h7, N, 4'h2, N, 64'hA, 64'h0, 64'h0);
`else
    chk("edep.stall", d_stall, 1'b1);
    push_bubble();
`endif
    tick("edep");
    clr_fwd();

    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
